// File: rtl/mcu_pkg.sv
// Shared definitions for the 8-bit microcontroller front end.
// Holds the default widths, the reset PC and the fetch state encoding.
package mcu_pkg;

   localparam int         ADDR_W_DEF   = 8;
   localparam int         INSTR_W_DEF  = 12;
   localparam logic [7:0] RESET_PC_DEF = 8'h00;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } fetch_state_e;

   // A program-memory read is outstanding in every state except HOLD.
   function automatic logic is_fetching(input fetch_state_e s);
      return s != HOLD;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: program-memory request/ack/data and the
// instruction register handshake towards the decoder.
// master = fetch_unit side, slave = memory/decoder side.
interface fetch_unit_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 12
);

   logic               mem_req;
   logic               mem_ack;
   logic [INSTR_W-1:0] mem_rdata;
   logic [INSTR_W-1:0] ir_out;
   logic               ir_valid;
   logic               ir_ready;

   modport master (
      output mem_req,
      input  mem_ack,
      input  mem_rdata,
      output ir_out,
      output ir_valid,
      input  ir_ready
   );

   modport slave (
      input  mem_req,
      output mem_ack,
      output mem_rdata,
      input  ir_out,
      input  ir_valid,
      output ir_ready
   );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, program-memory handshake, instruction register.
// Ports: clk, rst (sync, active high); pc_out -> adder/memory address,
// pc_inc <- adder output; load_en/load_addr redirect from execute;
// bus (master): mem_req/mem_ack/mem_rdata and ir_out/ir_valid/ir_ready.
module fetch_unit
   import mcu_pkg::*;
#(
   parameter int               ADDR_W   = ADDR_W_DEF,
   parameter int               INSTR_W  = INSTR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] pc_out,
   input  logic [ADDR_W-1:0] pc_inc,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   fetch_unit_if.master      bus
);

   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  pend_addr;
   logic [INSTR_W-1:0] ir;
   fetch_state_e       state;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_PC;
         pend_addr <= '0;
         ir        <= '0;
         state     <= REQ;
      end else begin
         unique case (state)
            REQ: begin
               if (bus.mem_ack) begin
                  // A same-cycle redirect drops the returned word.
                  if (load_en) begin
                     pc <= load_addr;
                  end else begin
                     ir    <= bus.mem_rdata;
                     state <= HOLD;
                  end
               end else if (load_en) begin
                  // pc must stay put until the open fetch is acked.
                  pend_addr <= load_addr;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               if (bus.mem_ack) begin
                  pc    <= load_en ? load_addr : pend_addr;
                  state <= REQ;
               end else if (load_en) begin
                  pend_addr <= load_addr;
               end
            end
            HOLD: begin
               if (load_en) begin
                  pc    <= load_addr;
                  state <= REQ;
               end else if (bus.ir_ready) begin
                  pc    <= pc_inc;
                  state <= REQ;
               end
            end
            default: state <= REQ;
         endcase
      end
   end

   assign pc_out       = pc;
   assign bus.mem_req  = !rst && is_fetching(state);
   assign bus.ir_valid = (state == HOLD);
   assign bus.ir_out   = ir;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 8-bit microcontroller. Holds the program counter and drives the program-memory request/acknowledge handshake. Latches each returned instruction word into an instruction register presented to the decoder with a valid/ready handshake. Drives the existing `adder` incrementer with the current PC and takes its output back as the sequential next address. Absolute jumps/branches redirect it through a load port.

## Interface
Parameters:
- ADDR_W, 8, program counter / program memory address width
- INSTR_W, 12, instruction word width
- RESET_PC, 8'h00, PC value loaded by reset

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pc_out  out  ADDR_W  current PC; drives `adder` In and program-memory address
- pc_inc  in  ADDR_W  PC+1 from `adder` Out
- mem_req  out  1  program-memory read request
- mem_ack  in  1  memory acknowledge; mem_rdata is valid in the same cycle
- mem_rdata  in  INSTR_W  instruction word from memory
- load_en  in  1  redirect request from execute stage (jump/branch taken)
- load_addr  in  ADDR_W  redirect target
- ir_out  out  INSTR_W  instruction register to decoder
- ir_valid  out  1  ir_out holds a live instruction
- ir_ready  in  1  decoder accepts ir_out

## Operation
- States:
  - REQ: fetch in flight
  - DRAIN: redirect pending behind an un-acked fetch
  - HOLD: instruction presented
- Registers: pc, pend_addr, ir, state.
- Memory rule: while mem_req=1, pc_out is stable until the edge at which mem_ack=1.
- REQ (mem_req=1, ir_valid=0):
  - mem_ack & !load_en: ir<=mem_rdata, go to HOLD.
  - mem_ack & load_en: data dropped, pc<=load_addr, stay in REQ.
  - !mem_ack & load_en: pend_addr<=load_addr, go to DRAIN.
  - Neither: stay in REQ.
- DRAIN (mem_req=1, ir_valid=0):
  - mem_ack: data dropped; pc<=load_addr if load_en this cycle, else pc<=pend_addr; go to REQ.
  - !mem_ack & load_en: pend_addr<=load_addr (latest redirect wins).
- HOLD (mem_req=0, ir_valid=1):
  - load_en: pc<=load_addr, instruction squashed, go to REQ. ir_ready is ignored in this cycle.
  - ir_ready & !load_en: pc<=pc_inc, go to REQ.
  - Otherwise: hold. ir_out and pc remain stable.
- Arithmetic: the increment is done externally by `adder`, modulo 2^ADDR_W, so 8'hFF is followed by 8'h00. No overflow flag.
- ir retains its last value outside HOLD; consumers qualify it with ir_valid.

## Timing
- Reset (rst=1 at an edge):
  - pc=RESET_PC, state=REQ, ir=0, pend_addr=0.
  - Outputs: pc_out=RESET_PC, mem_req=0 while rst is high, ir_valid=0, ir_out=0.
  - rst overrides every other input, including during DRAIN or HOLD; any in-flight fetch is abandoned.
- mem_req is state-decoded: it is high in REQ/DRAIN only when rst=0, so it rises in the first cycle after reset release.
- Minimum fetch latency: request cycle with same-cycle ack → ir_valid=1 in the next cycle.
- Maximum throughput: one instruction per 2 cycles (REQ, HOLD) with zero-wait memory and ir_ready held high.
- Redirect latency: after load_en in HOLD or in REQ with ack, mem_req for load_addr is issued in the next cycle. In DRAIN, mem_req for the target is issued the cycle after the old fetch is acked.
- No combinational path from ir_ready or load_en to mem_req or ir_valid.

## Structure
- Shared package `mcu_pkg`: ADDR_W/INSTR_W defaults, RESET_PC, fetch state enum {REQ, DRAIN, HOLD}.
- Single flat module. The FSM and registers stay inline.
- `adder` is instantiated by the parent, not inside fetch_unit, so the incrementer stays shareable.
- No further sub-module.

## Test plan
- Reset, zero-wait memory returning addr+12'h100, ir_ready=1 → fetches 0x00,0x01,0x02 appear on ir_out (12'h100,12'h101,12'h102), ir_valid asserted on every second cycle.
- PC at 8'hFF, ack and accept → next mem_req address 8'h00 (wrap).
- HOLD with ir_ready=0 for 5 cycles → ir_out and pc_out stable, mem_req=0; then ir_ready=1 → pc advances by one.
- REQ at 0x10, mem_ack withheld 3 cycles, load_en addr 0x40 then 0x50 during wait → pc_out stays 0x10 until ack; returned word is dropped (ir_valid stays 0); next request at 0x50.
- HOLD with load_en=1 and ir_ready=1 same cycle (target 0x80) → instruction squashed, next request at 0x80, not pc+1.
- rst asserted in DRAIN → next cycle mem_req=0, ir_valid=0, pc_out=RESET_PC; fetch restarts at RESET_PC after release.
